// File: rtl/uio_pkg.sv
// Shared types and constants for the uio strobe transmitter family.
package uio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STB_HI,
    ST_STB_LO
  } tx_state_t;

  localparam logic [7:0] UIO_OE_ALL  = 8'hFF;
  localparam logic [7:0] UIO_OE_NONE = 8'h00;

endpackage

// File: rtl/uio_strobe_tx_if.sv
// Byte input port plus strobe/ack pad handshake of uio_strobe_tx.
interface uio_strobe_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ack;
  logic       stb;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // master: the transmitter itself; slave: core logic plus external receiver
  modport master (
    input  in_data, in_valid, ack,
    output in_ready, stb, uio_out, uio_oe
  );

  modport slave (
    output in_data, in_valid, ack,
    input  in_ready, stb, uio_out, uio_oe
  );
endinterface

// File: rtl/uio_strobe_tx_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count    = wr_q - rd_q;
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uio_strobe_tx.sv
// Buffers bytes and drives them onto the uio pads with a four-phase stb/ack handshake.
module uio_strobe_tx
  import uio_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  uio_strobe_tx_if.master bus,
  output logic            busy,
  output logic            err
);
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = 1;
  localparam logic [CNTW-1:0] OCC_ONE  = 1;

  tx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      out_q, out_d;
  logic [7:0]      oe_q, oe_d;
  logic            stb_q, stb_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            push, pop, abort;
  logic            full, empty;
  logic [7:0]      head;
  logic [CNTW-1:0] occ, occ_d;

  assign push         = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign bus.stb      = stb_q;
  assign bus.uio_out  = out_q;
  assign bus.uio_oe   = oe_q;
  assign busy         = busy_q;
  assign err          = err_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );

  // Outputs are registered from the next state, so the pads already show the
  // popped byte in the SETUP cycle and stb rises only after a full setup cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    oe_d    = oe_q;
    stb_d   = stb_q;
    err_d   = err_q;
    pop     = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          out_d   = head;
          oe_d    = UIO_OE_ALL;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        stb_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_STB_HI;
      end
      ST_STB_HI: begin
        if (bus.ack) begin
          stb_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_STB_LO;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STB_LO: begin
        if (!bus.ack) begin
          if (!empty) begin
            pop     = 1'b1;
            out_d   = head;
            state_d = ST_SETUP;
          end else begin
            out_d   = '0;
            oe_d    = UIO_OE_NONE;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      stb_d   = 1'b0;
      out_d   = '0;
      oe_d    = UIO_OE_NONE;
      err_d   = 1'b1;
    end

    // busy is registered, so it looks ahead at next-cycle occupancy
    occ_d  = occ + (push ? OCC_ONE : '0) - (pop ? OCC_ONE : '0);
    busy_d = (state_d != ST_IDLE) || (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= UIO_OE_NONE;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uio_strobe_tx.sv
// Self-checking bench for uio_strobe_tx: scenario tasks plus a randomized scoreboard run.
module tb_uio_strobe_tx;

  logic clk;
  logic rst;
  logic busy;
  logic err;

  uio_strobe_tx_if bus();

  uio_strobe_tx #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        auto_ack = 1'b0;
  int unsigned max_dly  = 0;
  int          ack_wait = 0;

  // bytes seen on the pads at each stb rise, plus handshake-rule violations
  logic [7:0] obs[$];
  int         glitches = 0;
  logic       mon_stb  = 1'b0;
  logic [7:0] mon_oe   = 8'h00;
  logic [7:0] mon_out  = 8'h00;

  always @(posedge clk) begin
    #1;
    if (bus.stb && !mon_stb) begin
      obs.push_back(bus.uio_out);
      if (mon_oe !== bus.uio_oe) glitches++;
      if (bus.uio_oe !== 8'hFF) glitches++;
    end
    if (bus.stb && mon_stb && (bus.uio_out !== mon_out)) glitches++;
    mon_stb = bus.stb;
    mon_oe  = bus.uio_oe;
    mon_out = bus.uio_out;
  end

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    if (auto_ack && (bus.stb !== bus.ack)) begin
      if (ack_wait == 0) begin
        bus.ack  = bus.stb;
        ack_wait = int'($urandom_range(0, max_dly));
      end else begin
        ack_wait--;
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.ack      = 1'b0;
    auto_ack     = 1'b0;
    ack_wait     = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.ack      = 1'b0;
    tick();
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb: got %b want 0", bus.stb); end
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", bus.uio_out); end
    n_cmp++; if (bus.uio_oe !== 8'h00) begin n_bad++; $display("FAIL reset_oe: got %h want 00", bus.uio_oe); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.uio_oe !== 8'h00) begin n_bad++; $display("FAIL single_pop_cycle_oe: got %h want 00", bus.uio_oe); end
    tick();
    n_cmp++; if (bus.uio_oe !== 8'hFF) begin n_bad++; $display("FAIL single_setup_oe: got %h want FF", bus.uio_oe); end
    n_cmp++; if (bus.uio_out !== 8'hA5) begin n_bad++; $display("FAIL single_setup_out: got %h want A5", bus.uio_out); end
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL single_setup_stb: got %b want 0", bus.stb); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL single_stb_rise: got %b want 1", bus.stb); end
    tick();
    tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL single_stb_hold: got %b want 1", bus.stb); end
    bus.ack = 1'b1;
    tick();
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL single_stb_fall: got %b want 0", bus.stb); end
    n_cmp++; if (bus.uio_out !== 8'hA5) begin n_bad++; $display("FAIL single_lo_out: got %h want A5", bus.uio_out); end
    n_cmp++; if (bus.uio_oe !== 8'hFF) begin n_bad++; $display("FAIL single_lo_oe: got %h want FF", bus.uio_oe); end
    bus.ack = 1'b0;
    tick();
    n_cmp++; if (bus.uio_oe !== 8'h00) begin n_bad++; $display("FAIL single_idle_oe: got %h want 00", bus.uio_oe); end
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_bad++; $display("FAIL single_idle_out: got %h want 00", bus.uio_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill_stream();
    logic [7:0] exp[$];
    int base;
    int gap;
    int i;
    do_reset();
    base = obs.size();
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k);
      exp.push_back(8'(k));
      tick();
    end
    // one byte sits in the transmit register, four fill the FIFO
    bus.in_data = 8'hEE;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_full: got %b want 0", bus.in_ready); end
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_still_full: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    auto_ack = 1'b1;
    max_dly  = 0;
    gap = 0;
    for (i = 0; i < 200 && busy; i++) begin
      if ((obs.size() - base) < 5 && bus.uio_oe !== 8'hFF) gap++;
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_drain_timeout: busy got %b want 0", busy); end
    n_cmp++; if (gap !== 0) begin n_bad++; $display("FAIL stream_idle_gap: got %0d released cycles want 0", gap); end
    n_cmp++; if (obs.size() - base !== 5) begin n_bad++; $display("FAIL stream_count: got %0d want 5", obs.size() - base); end
    for (int k = 0; k < exp.size(); k++) begin
      n_cmp++;
      if (base + k >= obs.size() || obs[base + k] !== exp[k]) begin
        n_bad++;
        $display("FAIL stream_byte%0d: got %h want %h", k, (base + k < obs.size()) ? obs[base + k] : 8'hXX, exp[k]);
      end
    end
    auto_ack = 1'b0;
    bus.ack  = 1'b0;
  endtask

  task automatic test_timeout();
    int base;
    int n;
    do_reset();
    base = obs.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.stb; i++) tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL timeout_stb_wait: got %b want 1", bus.stb); end
    n = 0;
    while (bus.stb && n < 20) begin
      n++;
      tick();
    end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL timeout_hi_cycles: got %0d want 8", n); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    n_cmp++; if (bus.uio_oe !== 8'h00) begin n_bad++; $display("FAIL timeout_release_oe: got %h want 00", bus.uio_oe); end
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_bad++; $display("FAIL timeout_release_out: got %h want 00", bus.uio_out); end
    for (int i = 0; i < 12; i++) tick();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    n_cmp++; if (obs.size() - base !== 1) begin n_bad++; $display("FAIL timeout_dropped: got %0d strobes want 1", obs.size() - base); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_cleared: got %b want 0", err); end
  endtask

  task automatic test_stuck_high();
    int base;
    int n;
    do_reset();
    base = obs.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.stb; i++) tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL stuck_stb_wait: got %b want 1", bus.stb); end
    bus.ack = 1'b1;
    tick();
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL stuck_stb_fall: got %b want 0", bus.stb); end
    n = 0;
    while (bus.uio_oe === 8'hFF && n < 20) begin
      n++;
      tick();
    end
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL stuck_lo_cycles: got %0d want 8", n); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL stuck_err: got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stuck_idle: busy got %b want 0", busy); end
    bus.ack = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.stb; i++) tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL stuck_next_stb: got %b want 1", bus.stb); end
    n_cmp++; if (bus.uio_out !== 8'h77) begin n_bad++; $display("FAIL stuck_next_out: got %h want 77", bus.uio_out); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stuck_next_done: busy got %b want 0", busy); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL stuck_err_sticky: got %b want 1", err); end
    n_cmp++; if (obs.size() - base !== 2) begin n_bad++; $display("FAIL stuck_strobes: got %0d want 2", obs.size() - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hB1 + 8'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.stb; i++) tick();
    n_cmp++; if (bus.stb !== 1'b1) begin n_bad++; $display("FAIL rstmid_stb_wait: got %b want 1", bus.stb); end
    base = obs.size();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL rstmid_stb: got %b want 0", bus.stb); end
    n_cmp++; if (bus.uio_oe !== 8'h00) begin n_bad++; $display("FAIL rstmid_oe: got %h want 00", bus.uio_oe); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    rst = 1'b0;
    auto_ack = 1'b1;
    max_dly  = 1;
    for (int i = 0; i < 30; i++) tick();
    n_cmp++; if (obs.size() !== base) begin n_bad++; $display("FAIL rstmid_flushed: got %0d extra strobes want 0", obs.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: busy got %b want 0", busy); end
    auto_ack = 1'b0;
    bus.ack  = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    int base;
    int i;
    do_reset();
    base = obs.size();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0 + 8'(k);
      exp.push_back(8'hC0 + 8'(k));
      tick();
    end
    bus.in_valid = 1'b0;
    for (i = 0; i < 10 && !bus.stb; i++) tick();
    bus.ack = 1'b1;
    tick();
    n_cmp++; if (bus.stb !== 1'b0) begin n_bad++; $display("FAIL wrap_in_stb_lo: stb got %b want 0", bus.stb); end
    // DEPTH-1 queued: push lands in the same edge that STB_LO pops
    bus.ack      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC4;
    exp.push_back(8'hC4);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready_before: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready_after: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.uio_out !== 8'hC1) begin n_bad++; $display("FAIL wrap_setup_out: got %h want C1", bus.uio_out); end
    auto_ack = 1'b1;
    max_dly  = 2;
    for (i = 0; i < 200 && busy; i++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_drain_timeout: busy got %b want 0", busy); end
    for (int k = 0; k < exp.size(); k++) begin
      n_cmp++;
      if (base + k >= obs.size() || obs[base + k] !== exp[k]) begin
        n_bad++;
        $display("FAIL wrap_byte%0d: got %h want %h", k, (base + k < obs.size()) ? obs[base + k] : 8'hXX, exp[k]);
      end
    end
    auto_ack = 1'b0;
    bus.ack  = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    int base;
    int g0;
    int i;
    do_reset();
    base     = obs.size();
    g0       = glitches;
    auto_ack = 1'b1;
    max_dly  = 3;
    for (int c = 0; c < 120; c++) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data  = 8'($urandom);
      if (bus.in_valid && bus.in_ready) exp.push_back(bus.in_data);
      tick();
    end
    bus.in_valid = 1'b0;
    for (i = 0; i < 400 && busy; i++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL random_drain_timeout: busy got %b want 0", busy); end
    n_cmp++; if (obs.size() - base !== exp.size()) begin n_bad++; $display("FAIL random_count: got %0d want %0d", obs.size() - base, exp.size()); end
    for (int k = 0; k < exp.size(); k++) begin
      n_cmp++;
      if (base + k >= obs.size() || obs[base + k] !== exp[k]) begin
        n_bad++;
        $display("FAIL random_byte%0d: got %h want %h", k, (base + k < obs.size()) ? obs[base + k] : 8'hXX, exp[k]);
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL random_err: got %b want 0", err); end
    n_cmp++; if (glitches - g0 !== 0) begin n_bad++; $display("FAIL random_strobe_rules: got %0d violations want 0", glitches - g0); end
    auto_ack = 1'b0;
    bus.ack  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.ack      = 1'b0;
    test_reset();
    test_single();
    test_fill_stream();
    test_timeout();
    test_stuck_high();
    test_reset_mid();
    test_wrap();
    test_random();
    n_cmp++; if (glitches !== 0) begin n_bad++; $display("FAIL strobe_rules_total: got %0d violations want 0", glitches); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
